// File: rtl/sample_accumulator.sv
// -----------------------------------------------------------------------------
// sample_accumulator
//
// Purpose:
//   Sums a fixed-length frame of NUMBER_OF_SAMPLES signed samples. Each sample
//   comes from the sign-extension stage. The block presents one saturated
//   signed result per frame over a valid/ready handshake. A frame's result is
//   held stable until it is consumed downstream. The first sample of the next
//   frame can be taken one cycle after the result handshake.
//
// Parameters:
//   WIDTH_OF_INPUT_DATA  - width of signed input samples (two's complement)
//   WIDTH_OF_OUTPUT_DATA - width of signed, saturated result
//   NUMBER_OF_SAMPLES    - samples per frame (>= 1)
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst          - synchronous, active-high reset
//   input_data   - signed sample
//   input_valid  - input_data is valid this cycle
//   input_ready  - block accepts a sample this cycle (registered, state only)
//   output_data  - signed frame sum, saturated to the output range
//   output_valid - output_data / saturated are valid (registered, state only)
//   output_ready - downstream consumes the result this cycle
//   saturated    - the frame sum was clipped to the output range
// -----------------------------------------------------------------------------
module sample_accumulator #(
  parameter int WIDTH_OF_INPUT_DATA  = 16,
  parameter int WIDTH_OF_OUTPUT_DATA = 16,
  parameter int NUMBER_OF_SAMPLES    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic signed [WIDTH_OF_INPUT_DATA-1:0]  input_data,
  input  logic                                   input_valid,
  output logic                                   input_ready,
  output logic signed [WIDTH_OF_OUTPUT_DATA-1:0] output_data,
  output logic                                   output_valid,
  input  logic                                   output_ready,
  output logic                                   saturated
);

  // The accumulator has enough headroom for a full frame of extreme samples.
  // As a result, the frame sum itself never wraps.
  localparam int ACC_W = WIDTH_OF_INPUT_DATA + $clog2(NUMBER_OF_SAMPLES) + 1;
  localparam int CNT_W = $clog2(NUMBER_OF_SAMPLES + 1);

  // The saturation compare is done one bit wider than both the accumulator
  // and the output. This keeps the MAX/MIN bounds representable in every
  // parameterisation. When the output is at least as wide as the accumulator,
  // the compare then never trips, so the result is simply sign-extended.
  localparam int CMP_W = ((ACC_W > WIDTH_OF_OUTPUT_DATA) ? ACC_W : WIDTH_OF_OUTPUT_DATA) + 1;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUMBER_OF_SAMPLES - 1);

  localparam logic signed [CMP_W-1:0] SAT_MAX =
    {{(CMP_W - WIDTH_OF_OUTPUT_DATA + 1){1'b0}}, {(WIDTH_OF_OUTPUT_DATA - 1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN =
    {{(CMP_W - WIDTH_OF_OUTPUT_DATA + 1){1'b1}}, {(WIDTH_OF_OUTPUT_DATA - 1){1'b0}}};

  typedef enum logic {
    ACCUMULATE = 1'b0,
    HOLD       = 1'b1
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;

  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic [WIDTH_OF_OUTPUT_DATA:0] sat_result;

  // Clips a frame sum into the output range.
  // The MSB of the return value is the saturation flag.
  // The remaining bits are the clipped, or plainly truncated, sum.
  function automatic logic [WIDTH_OF_OUTPUT_DATA:0] saturate(
    input logic signed [ACC_W-1:0] value
  );
    logic signed [CMP_W-1:0] wide;
    wide = CMP_W'(value);
    if (wide > SAT_MAX) begin
      return {1'b1, SAT_MAX[WIDTH_OF_OUTPUT_DATA-1:0]};
    end else if (wide < SAT_MIN) begin
      return {1'b1, SAT_MIN[WIDTH_OF_OUTPUT_DATA-1:0]};
    end else begin
      return {1'b0, wide[WIDTH_OF_OUTPUT_DATA-1:0]};
    end
  endfunction

  // Sign-extend the incoming sample and form the running sum.
  assign sample_ext = ACC_W'(input_data);
  assign sum_next   = acc + sample_ext;
  assign sat_result = saturate(sum_next);

  // Control FSM.
  // input_ready and output_valid are registered alongside the state, so they
  // have no combinational path from any input. In ACCUMULATE, input_ready is
  // known to be 1, so input_valid alone qualifies an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUMULATE;
      acc          <= '0;
      count        <= '0;
      output_data  <= '0;
      saturated    <= 1'b0;
      output_valid <= 1'b0;
      input_ready  <= 1'b1;
    end else begin
      case (state)
        ACCUMULATE: begin
          if (input_valid) begin
            acc <= sum_next;
            if (count == LAST_COUNT) begin
              {saturated, output_data} <= sat_result;
              count        <= '0;
              state        <= HOLD;
              input_ready  <= 1'b0;
              output_valid <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // The result registers are left untouched here, so they stay
          // stable. input_valid is deliberately not looked at.
          if (output_ready) begin
            acc          <= '0;
            state        <= ACCUMULATE;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ACCUMULATE;
          acc          <= '0;
          count        <= '0;
          input_ready  <= 1'b1;
          output_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sample_accumulator
//
// Self-checking bench for sample_accumulator at its default parameters
// (16 / 16 / 4). It uses directed scenarios followed by randomized frames.
// Expected results come from a frame-level reference model: the plain integer
// sum of the frame's samples, clipped to the 16-bit signed range.
// -----------------------------------------------------------------------------
module tb_sample_accumulator;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] input_data;
  logic               input_valid;
  logic               input_ready;
  logic signed [15:0] output_data;
  logic               output_valid;
  logic               output_ready;
  logic               saturated;

  int checks   = 0;
  int failures = 0;

  sample_accumulator #(
    .WIDTH_OF_INPUT_DATA (16),
    .WIDTH_OF_OUTPUT_DATA(16),
    .NUMBER_OF_SAMPLES   (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_data  (input_data),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .output_data (output_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and wait, with a bound, until it is accepted.
  // The task returns #1 after the accepting edge.
  task automatic send(input logic signed [15:0] v, input string tag);
    int guard;
    guard = 0;
    input_valid = 1'b1;
    input_data  = v;
    while (input_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk({tag, "_accept_timeout"}, 0, 1);
    tick();
    input_valid = 1'b0;
  endtask

  // Runs one whole frame against the reference model.
  // gap idle cycles are inserted after sample index gap_at (no gap if >= N-1).
  // hold > 0 keeps output_ready low for that many cycles in HOLD while
  // junk is driven on the input.
  task automatic do_frame(input logic signed [15:0] s0, input logic signed [15:0] s1,
                          input logic signed [15:0] s2, input logic signed [15:0] s3,
                          input int gap_at, input int gap, input int hold,
                          input string tag);
    logic signed [15:0] smp[N];
    logic signed [63:0] sum;
    logic signed [63:0] exp_data;
    logic               exp_sat;
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    output_ready = (hold == 0);
    sum = 0;
    for (int i = 0; i < N; i++) begin
      sum = sum + smp[i];
      send(smp[i], tag);
      if (i < N - 1) begin
        chk({tag, "_out_valid_mid"}, output_valid, 0);
        if (i == gap_at) begin
          for (int g = 0; g < gap; g++) begin
            tick();
            chk({tag, "_gap_in_ready"}, input_ready, 1);
          end
        end
      end
    end
    if (sum > 32767) begin
      exp_data = 32767;  exp_sat = 1'b1;
    end else if (sum < -32768) begin
      exp_data = -32768; exp_sat = 1'b1;
    end else begin
      exp_data = sum;    exp_sat = 1'b0;
    end
    // This point is one cycle after the final accept.
    chk({tag, "_out_valid"}, output_valid, 1);
    chk({tag, "_in_ready_hold"}, input_ready, 0);
    chk({tag, "_data"}, output_data, exp_data);
    chk({tag, "_sat"}, saturated, exp_sat);
    if (hold > 0) begin
      input_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        input_data = 16'($urandom);
        tick();
        chk({tag, "_hold_valid"}, output_valid, 1);
        chk({tag, "_hold_in_ready"}, input_ready, 0);
        chk({tag, "_hold_data"}, output_data, exp_data);
        chk({tag, "_hold_sat"}, saturated, exp_sat);
      end
      input_valid  = 1'b0;
      output_ready = 1'b1;
    end
    tick();
    chk({tag, "_release_valid"}, output_valid, 0);
    chk({tag, "_release_in_ready"}, input_ready, 1);
  endtask

  initial begin
    logic signed [15:0] r[N];
    rst          = 1'b1;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;
    repeat (2) tick();
    chk("reset_out_valid", output_valid, 0);
    chk("reset_in_ready", input_ready, 1);
    chk("reset_data", output_data, 0);
    chk("reset_sat", saturated, 0);
    rst = 1'b0;
    tick();

    // Basic frame with output_ready held high.
    do_frame(1, 2, 3, 4, N, 0, 0, "basic");
    // Saturation at both rails.
    do_frame(-32768, -32768, -32768, -32768, N, 0, 0, "neg_sat");
    do_frame(32767, 32767, 32767, 32767, N, 0, 0, "pos_sat");
    // Gaps in the stream, then backpressure in HOLD.
    do_frame(-5, 3, -1, 7, 1, 3, 5, "gaps_bp");
    do_frame(9, 9, 9, 9, N, 0, 0, "after_bp");

    // Mid-frame reset: partial sum discarded, and rst wins over a valid sample.
    send(100, "midrst");
    send(200, "midrst");
    rst         = 1'b1;
    input_valid = 1'b1;
    input_data  = 500;
    tick();
    rst         = 1'b0;
    input_valid = 1'b0;
    chk("midrst_out_valid", output_valid, 0);
    chk("midrst_in_ready", input_ready, 1);
    chk("midrst_data", output_data, 0);
    chk("midrst_sat", saturated, 0);
    do_frame(1, 1, 1, 1, N, 0, 0, "after_rst");

    // Randomized frames, some biased toward the rails to exercise clipping.
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       r[i] = 16'(32767 - $urandom_range(0, 300));
          1:       r[i] = 16'(-32768 + $urandom_range(0, 300));
          default: r[i] = 16'($urandom);
        endcase
      end
      do_frame(r[0], r[1], r[2], r[3], $urandom_range(0, N - 1),
               $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Sequential consumer of sign-extended samples: accepts a stream of signed words over a valid/ready handshake, sums a fixed-length frame of `NUMBER_OF_SAMPLES` words, and presents one saturated signed result per frame. It sits directly downstream of the sign-extension stage, whose output feeds `input_data`. The result feeds the next datapath stage through a valid/ready handshake.

## Interface
- `WIDTH_OF_INPUT_DATA`, default 16: width of signed input samples, two's complement.
- `WIDTH_OF_OUTPUT_DATA`, default 16: width of the signed, saturated result.
- `NUMBER_OF_SAMPLES`, default 4: samples per frame; must be ≥ 1.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `input_data` input `WIDTH_OF_INPUT_DATA`: signed sample from the sign-extension stage.
- `input_valid` input 1: `input_data` is valid this cycle.
- `input_ready` output 1: block accepts a sample this cycle.
- `output_data` output `WIDTH_OF_OUTPUT_DATA`: signed frame sum, saturated.
- `output_valid` output 1: `output_data` and `saturated` are valid.
- `output_ready` input 1: downstream consumes the result this cycle.
- `saturated` output 1: the frame sum was clipped to the output range.

## Operation
- The block has an internal accumulator of width `WIDTH_OF_INPUT_DATA + $clog2(NUMBER_OF_SAMPLES) + 1`, signed. Frame sums cannot overflow internally.
- It has a sample counter of width `$clog2(NUMBER_OF_SAMPLES + 1)`, counting 0 to `NUMBER_OF_SAMPLES - 1`.
- Each accepted sample is sign-extended to the accumulator width before the add.
- FSM states are ACCUMULATE and HOLD.
- **ACCUMULATE**
  - `input_ready` = 1 and `output_valid` = 0.
  - A sample is accepted only when `input_valid` and `input_ready` are both high.
  - On each accept:
    - accumulator ← accumulator + sample;
    - counter increments.
  - On accept with counter = `NUMBER_OF_SAMPLES - 1`:
    - the final sum (accumulator + sample) is saturated and registered into `output_data` / `saturated`;
    - the counter returns to 0;
    - the FSM moves to HOLD.
- **HOLD**
  - `input_ready` = 0 and `output_valid` = 1.
  - `output_data` and `saturated` stay stable.
  - `input_valid` is ignored and no sample is consumed.
  - When `output_ready` = 1: the accumulator clears to 0 and the FSM moves to ACCUMULATE.
- **Saturation**
  - Let MAX = 2^(`WIDTH_OF_OUTPUT_DATA` - 1) - 1 and MIN = -2^(`WIDTH_OF_OUTPUT_DATA` - 1).
  - Sum > MAX → `output_data` = MAX and `saturated` = 1.
  - Sum < MIN → `output_data` = MIN and `saturated` = 1.
  - Otherwise `output_data` = sum truncated to output width and `saturated` = 0.
- `NUMBER_OF_SAMPLES` = 1: every accepted sample goes straight to HOLD, with saturation applied.
- `WIDTH_OF_OUTPUT_DATA` > accumulator width: the result is sign-extended and `saturated` is never set.

## Timing
- **Reset values** (at the first rising edge with `rst` = 1):
  - state = ACCUMULATE, accumulator = 0, counter = 0;
  - `output_data` = 0, `saturated` = 0, `output_valid` = 0, `input_ready` = 1.
- **Reset mid-frame or in HOLD:** the partial sum and any pending result are discarded with no output. `rst` has priority over every handshake in the same cycle.
- **Latency:** the final sample is accepted at edge t; `output_valid` = 1 in the cycle after edge t.
- **Throughput:** the minimum frame period is `NUMBER_OF_SAMPLES` + 1 cycles, i.e. `NUMBER_OF_SAMPLES` accept cycles plus 1 HOLD cycle with `output_ready` held high.
- **First sample of the next frame:** it can be accepted in the cycle after the HOLD handshake completes, never in the same cycle.
- **Handshake outputs:** `input_ready` and `output_valid` depend only on the FSM state and have no combinational path from inputs.
- **`input_valid` low:** the accumulator and counter hold, so gaps in the stream are allowed.

## Test plan
All scenarios use the defaults (16 / 16 / 4).
- **Basic frame:** samples 1, 2, 3, 4 with `input_valid` held high and `output_ready` = 1 → `output_valid` the cycle after the 4th accept, `output_data` = 10, `saturated` = 0, then `input_ready` back to 1.
- **Negative saturation:** -32768 ×4 → `output_data` = -32768, `saturated` = 1.
- **Positive saturation:** 32767 ×4 → `output_data` = 32767, `saturated` = 1.
- **Gaps:** -5, 3, then 3 idle cycles, then -1, 7 → `output_data` = 4, `saturated` = 0.
- **Backpressure:**
  - Hold `output_ready` = 0 for 5 cycles in HOLD while driving `input_valid` = 1 with value 9 → `output_data` stays stable, `input_ready` = 0, no sample consumed.
  - Then raise `output_ready` and send the next frame of 9 ×4 → `output_data` = 36.
- **Mid-frame reset:** accept 100, 200, then assert `rst` for 1 cycle, then send 1, 1, 1, 1 → all outputs at reset values after reset, then the next result is 4.
